// File: rtl/dmem_scan_pkg.sv
// Shared types and constants for the data-memory scanner and the BRAM it reads.
// DMEM_DEPTH must match the depth of the data-memory instantiation at the top level.
package dmem_scan_pkg;

  localparam int DMEM_DEPTH = 1024;
  localparam int ADDR_W     = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous button inputs; output lags input by 2 cycles.
// No handshake: the sampled level simply follows the input.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta  <= '0;
      q_out <= '0;
    end else begin
      meta  <= d_in;
      q_out <= meta;
    end
  end

endmodule

// File: rtl/dmem_scanner.sv
// Walks data memory ADDR_LO..ADDR_HI after core completion, holding each {addr, data} for DWELL_CYCLES.
// First word lands READ_LATENCY+1 edges after start; a synchronized hold freezes the dwell in place.
module dmem_scanner
  import dmem_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_LO      = 0,
  parameter int ADDR_HI      = 9
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        hold_in,
  output logic        rd_en_out,
  output logic [31:0] rd_addr_out,
  input  logic [31:0] rd_data_in,
  output logic [31:0] val_out,
  output logic        val_valid_out,
  output logic        scanning_out
);

  localparam int                CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_CAP  = CNT_W'(READ_LATENCY);
  localparam logic [ADDR_W-1:0] A_LO     = ADDR_W'(ADDR_LO);
  localparam logic [ADDR_W-1:0] A_HI     = ADDR_W'(ADDR_HI);

  scan_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              hold_s;
  logic              unused_rd_hi;

  sync_2ff #(.WIDTH(1)) u_hold_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (hold_in),
    .q_out  (hold_s)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      addr          <= A_LO;
      val_out       <= '0;
      val_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          addr <= A_LO;
          if (start_in) state <= SCAN;
        end
        SCAN: begin
          // Data read at cnt==0 is on the BRAM output once cnt reaches READ_LATENCY,
          // so the capture completes as cnt steps to READ_LATENCY+1.
          if (cnt == CNT_CAP) begin
            val_out       <= {16'(addr), rd_data_in[15:0]};
            val_valid_out <= 1'b1;
          end
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            addr <= (addr == A_HI) ? A_LO : addr + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (hold_s) state <= HOLD;
        end
        HOLD: begin
          if (!hold_s) state <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_en_out    = (state == SCAN) && (cnt == '0);
  assign rd_addr_out  = 32'(addr);
  assign scanning_out = (state != IDLE);
  assign unused_rd_hi = ^rd_data_in[31:16];

  a_dwell_fits: assert property (@(posedge clk_in) DWELL_CYCLES > READ_LATENCY + 1);
  a_addr_order: assert property (@(posedge clk_in) ADDR_LO <= ADDR_HI);
  a_addr_range: assert property (@(posedge clk_in) ADDR_HI < DMEM_DEPTH);

endmodule

// File: tb/tb_dmem_scanner.sv
// Directed bench for dmem_scanner: DWELL_CYCLES=8, addresses 0..2, 2-cycle BRAM model.
// t counts falling edges after the edge that sampled start (t=0 is the first cycle of SCAN).
module tb_dmem_scanner;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        hold  = 1'b0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] val;
  logic        val_vld;
  logic        scanning;

  logic [31:0] mem [0:2];
  logic [31:0] bram_r1 = 32'd0;
  logic [31:0] bram_r2 = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  always #5 clk = ~clk;

  dmem_scanner #(
    .DWELL_CYCLES (8),
    .READ_LATENCY (2),
    .ADDR_LO      (0),
    .ADDR_HI      (2)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .hold_in       (hold),
    .rd_en_out     (rd_en),
    .rd_addr_out   (rd_addr),
    .rd_data_in    (rd_data),
    .val_out       (val),
    .val_valid_out (val_vld),
    .scanning_out  (scanning)
  );

  // Two-stage BRAM read port: address register, then output register that keeps its value.
  always @(posedge clk) begin
    if (rd_en) bram_r1 <= (rd_addr < 32'd3) ? mem[rd_addr[1:0]] : 32'hDEAD_BEEF;
    bram_r2 <= bram_r1;
  end
  assign rd_data = bram_r2;

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic run_to(input int tt);
    while (t < tt) tick();
  endtask

  task automatic do_reset();
    hold  = 1'b0;
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_scan();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_en, val_vld, scanning, val, rd_addr} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: en/vld/scan/val/addr got %b %b %b %h %h, want all zero",
               rd_en, val_vld, scanning, val, rd_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_en, val_vld, scanning, val} !== 35'd0) begin
        n_fail++;
        $display("FAIL idle_no_start cyc %0d: en/vld/scan/val got %b %b %b %h, want 0 0 0 0",
                 k, rd_en, val_vld, scanning, val);
      end
    end
  endtask

  task automatic test_scan();
    int pulses;
    do_reset();
    start_scan();
    pulses = 0;
    n_checks++;
    if ({rd_en, rd_addr, scanning} !== {1'b1, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL scan_first_read: en/addr/scan got %b %h %b, want 1 0 1", rd_en, rd_addr, scanning);
    end
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      pulses += int'(rd_en);
      n_checks++;
      if (rd_en !== (t % 8 == 0)) begin
        n_fail++;
        $display("FAIL scan_rd_en t=%0d: got %b, want %b", t, rd_en, (t % 8 == 0));
      end
      if (t == 2) begin
        n_checks++;
        if ({val_vld, val} !== 33'd0) begin
          n_fail++;
          $display("FAIL scan_before_capture: vld/val got %b %h, want 0 0", val_vld, val);
        end
      end
      if (t == 3) begin
        n_checks++;
        if ({val_vld, val} !== {1'b1, 32'h0000_000A}) begin
          n_fail++;
          $display("FAIL scan_first_word: vld/val got %b %h, want 1 0000000a", val_vld, val);
        end
      end
      if (t == 16) begin
        n_checks++;
        if (rd_addr !== 32'd2) begin
          n_fail++;
          $display("FAIL scan_addr2: rd_addr got %h, want 2", rd_addr);
        end
      end
      if (t == 11 || t == 19 || t == 27) begin
        logic [31:0] exp;
        exp = (t == 11) ? 32'h0001_000B : (t == 19) ? 32'h0002_000C : 32'h0000_000A;
        n_checks++;
        if (val !== exp) begin
          n_fail++;
          $display("FAIL scan_word t=%0d: val got %h, want %h", t, val, exp);
        end
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL scan_pulse_count: got %0d pulses in 32 cycles, want 4", pulses);
    end
  endtask

  task automatic test_hold_mid_dwell();
    do_reset();
    start_scan();
    run_to(12);
    hold = 1'b1;
    while (t < 40) begin
      tick();
      if (t == 32) hold = 1'b0;
      if (t >= 13 && t <= 35) begin
        n_checks++;
        if ({rd_en, val, scanning} !== {1'b0, 32'h0001_000B, 1'b1}) begin
          n_fail++;
          $display("FAIL hold_frozen t=%0d: en/val/scan got %b %h %b, want 0 0001000b 1",
                   t, rd_en, val, scanning);
        end
      end
      if (t == 35) begin
        n_checks++;
        if (rd_addr !== 32'd1) begin
          n_fail++;
          $display("FAIL hold_addr_kept: rd_addr got %h, want 1", rd_addr);
        end
      end
      if (t == 36) begin
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 32'd2}) begin
          n_fail++;
          $display("FAIL hold_addr2_delayed: en/addr got %b %h, want 1 2", rd_en, rd_addr);
        end
      end
      if (t == 38 || t == 39) begin
        logic [31:0] exp;
        exp = (t == 38) ? 32'h0001_000B : 32'h0002_000C;
        n_checks++;
        if (val !== exp) begin
          n_fail++;
          $display("FAIL hold_after_release t=%0d: val got %h, want %h", t, val, exp);
        end
      end
    end
  endtask

  task automatic test_hold_before_capture();
    do_reset();
    start_scan();
    run_to(15);
    hold = 1'b1;
    while (t < 36) begin
      tick();
      if (t == 25) hold = 1'b0;
      if (t == 16) begin
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 32'd2}) begin
          n_fail++;
          $display("FAIL hbc_issue: en/addr got %b %h, want 1 2", rd_en, rd_addr);
        end
      end
      if (t >= 17 && t <= 33) begin
        n_checks++;
        if (rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL hbc_no_read t=%0d: rd_en got %b, want 0", t, rd_en);
        end
      end
      if (t >= 17 && t <= 28) begin
        n_checks++;
        if (val !== 32'h0001_000B) begin
          n_fail++;
          $display("FAIL hbc_pending t=%0d: val got %h, want 0001000b", t, val);
        end
      end
      if (t == 29) begin
        n_checks++;
        if (val !== 32'h0002_000C) begin
          n_fail++;
          $display("FAIL hbc_capture: val got %h, want 0002000c", val);
        end
      end
      if (t == 34) begin
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 32'd0}) begin
          n_fail++;
          $display("FAIL hbc_wrap: en/addr got %b %h, want 1 0", rd_en, rd_addr);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    start_scan();
    while (t < 20) begin
      tick();
      start = (t == 5) || (t >= 12 && t <= 14);
      n_checks++;
      if ({rd_en, scanning} !== {(t == 8 || t == 16), 1'b1}) begin
        n_fail++;
        $display("FAIL restart_schedule t=%0d: en/scan got %b %b, want %b 1",
                 t, rd_en, scanning, (t == 8 || t == 16));
      end
      if (t == 8 || t == 16) begin
        n_checks++;
        if (rd_addr !== ((t == 8) ? 32'd1 : 32'd2)) begin
          n_fail++;
          $display("FAIL restart_addr t=%0d: rd_addr got %h, want %h", t, rd_addr, (t == 8) ? 32'd1 : 32'd2);
        end
      end
      if (t == 11 || t == 19) begin
        n_checks++;
        if (val !== ((t == 11) ? 32'h0001_000B : 32'h0002_000C)) begin
          n_fail++;
          $display("FAIL restart_val t=%0d: val got %h", t, val);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    start_scan();
    run_to(9);
    n_checks++;
    if ({val_vld, val, rd_addr} !== {1'b1, 32'h0000_000A, 32'd1}) begin
      n_fail++;
      $display("FAIL arst_precond: vld/val/addr got %b %h %h, want 1 0000000a 1", val_vld, val, rd_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_en, rd_addr, val, val_vld, scanning} !== 67'd0) begin
      n_fail++;
      $display("FAIL arst_immediate: en/addr/val/vld/scan got %b %h %h %b %b, want all zero",
               rd_en, rd_addr, val, val_vld, scanning);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if ({rd_en, val, val_vld, scanning} !== 35'd0) begin
        n_fail++;
        $display("FAIL arst_idle cyc %0d: en/val/vld/scan got %b %h %b %b", k, rd_en, val, val_vld, scanning);
      end
    end
    start_scan();
    n_checks++;
    if ({rd_en, rd_addr, scanning} !== {1'b1, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_restart_read: en/addr/scan got %b %h %b, want 1 0 1", rd_en, rd_addr, scanning);
    end
    run_to(3);
    n_checks++;
    if ({val_vld, val} !== {1'b1, 32'h0000_000A}) begin
      n_fail++;
      $display("FAIL arst_restart_word: vld/val got %b %h, want 1 0000000a", val_vld, val);
    end
  endtask

  initial begin
    mem[0] = 32'h0000_000A;
    mem[1] = 32'h0000_000B;
    mem[2] = 32'h0000_000C;
    test_reset();
    test_scan();
    test_hold_mid_dwell();
    test_hold_before_capture();
    test_start_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
